seq_state_wrapper: RTL and testbench

//  Closes the loop around a "_comb" benchmark netlist (e.g. s713_comb): holds the extracted

---
 rtl/seq_wrap_pkg.sv | 35 +++
 rtl/scan_shift_ctrl.sv | 65 ++++++
 rtl/seq_state_wrapper.sv | 99 +++++++++
 tb/tb_seq_state_wrapper.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_wrap_pkg.sv
// Shared types and helpers for the sequential wrapper around a "_comb" benchmark core.
// Used by scan_shift_ctrl and seq_state_wrapper (MISR helpers only with STATE_MISR_EN).
package seq_wrap_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} scan_st_e;

  localparam int          MISR_W_DEF    = 16;
  localparam logic [15:0] MISR_POLY_DEF = 16'h8016;
  // Container width for the width-generic helpers below.
  localparam int          MAX_W         = 256;

  // One Galois step, shifting toward the MSB; only the low w bits are meaningful.
  function automatic logic [MAX_W-1:0] lfsr_step(input logic [MAX_W-1:0] s,
                                                 input logic [MAX_W-1:0] poly,
                                                 input int               w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 1; i < MAX_W; i++)
      if (i < w) r[i] = s[i-1];
    if (s[w-1]) r = r ^ poly;
    return r;
  endfunction

  // XOR-fold an sw-bit vector down to w bits: bit i lands on bit i % w.
  function automatic logic [MAX_W-1:0] fold(input logic [MAX_W-1:0] v,
                                            input int               sw,
                                            input int               w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++)
      if (i < sw) r[i % w] = r[i % w] ^ v[i];
    return r;
  endfunction

endpackage

// File: rtl/scan_shift_ctrl.sv
// Scan sequencer: IDLE/SHIFT/DONE FSM with beat counter. Produces the shift enable for
// scan beats, the functional capture enable and the one-cycle done pulse.
module scan_shift_ctrl
  import seq_wrap_pkg::*;
#(
  parameter int CHAIN_LEN = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_en,
  input  logic step,
  input  logic scan_start,
  input  logic scan_abort,
  input  logic si_valid,
  input  logic so_ready,
  output logic shift_en,
  output logic cap_en,
  output logic done,
  output logic ready
);

  localparam int CNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  scan_st_e         state, state_nxt;
  logic [CNT_W-1:0] beat_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    cap_en    = 1'b0;
    done      = 1'b0;
    ready     = 1'b0;
    unique case (state)
      IDLE: begin
        ready  = 1'b1;
        cap_en = (run_en | step) & ~scan_start;
        if (scan_start) state_nxt = SHIFT;
      end
      SHIFT: begin
        // Abort beats any concurrent handshake: the beat is dropped.
        shift_en = si_valid & so_ready & ~scan_abort;
        if (scan_abort)                       state_nxt = IDLE;
        else if (shift_en && beat_cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        beat_cnt <= '0;
    else if (state == IDLE && scan_start) beat_cnt <= '0;
    else if (shift_en)                 beat_cnt <= beat_cnt + 1'b1;
  end

endmodule

// File: rtl/seq_state_wrapper.sv
// Sequential shell around a combinational benchmark core: state register, multi-chain
// scan swap and single-step capture. Optional signature MISR under `STATE_MISR_EN.
module seq_state_wrapper
  import seq_wrap_pkg::*;
#(
  parameter int                 STATE_W   = 15,
  parameter int                 CHAINS    = 3,
  parameter logic [STATE_W-1:0] RESET_VAL = '0,
  parameter int                 MISR_W    = MISR_W_DEF,
  parameter logic [MISR_W-1:0]  MISR_POLY = MISR_POLY_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STATE_W-1:0] ns_i,
  output logic [STATE_W-1:0] ps_o,
  input  logic               run_en_i,
  input  logic               step_i,
  input  logic               scan_start_i,
  output logic               scan_ready_o,
  input  logic               scan_abort_i,
  input  logic               si_valid_i,
  input  logic [CHAINS-1:0]  si_data_i,
  input  logic               so_ready_i,
  output logic [CHAINS-1:0]  so_data_o,
`ifdef STATE_MISR_EN
  output logic [MISR_W-1:0]  sig_o,
  input  logic               sig_clr_i,
`endif
  output logic               scan_done_o
);

  localparam int CHAIN_LEN = STATE_W / CHAINS;

  if (STATE_W % CHAINS != 0) begin : g_bad_chains
    $error("seq_state_wrapper: STATE_W must be a multiple of CHAINS");
  end

  logic               shift_en, cap_en;
  logic [STATE_W-1:0] ps, ps_shift;

  scan_shift_ctrl #(.CHAIN_LEN(CHAIN_LEN)) u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_en     (run_en_i),
    .step       (step_i),
    .scan_start (scan_start_i),
    .scan_abort (scan_abort_i),
    .si_valid   (si_valid_i),
    .so_ready   (so_ready_i),
    .shift_en   (shift_en),
    .cap_en     (cap_en),
    .done       (scan_done_o),
    .ready      (scan_ready_o)
  );

  // Each chain shifts toward its MSB; the MSB is the chain's scan-out bit.
  for (genvar c = 0; c < CHAINS; c++) begin : g_chain
    assign so_data_o[c] = ps[c*CHAIN_LEN + CHAIN_LEN - 1];
    if (CHAIN_LEN == 1) begin : g_len1
      assign ps_shift[c] = si_data_i[c];
    end else begin : g_lenn
      assign ps_shift[c*CHAIN_LEN +: CHAIN_LEN] =
        {ps[c*CHAIN_LEN +: CHAIN_LEN-1], si_data_i[c]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ps <= RESET_VAL;
    else if (shift_en) ps <= ps_shift;
    else if (cap_en)   ps <= ns_i;
  end

  assign ps_o = ps;

`ifdef STATE_MISR_EN
  if (STATE_W > MAX_W || MISR_W > MAX_W) begin : g_bad_misr
    $error("seq_state_wrapper: STATE_W/MISR_W exceed MISR helper width");
  end

  logic [MISR_W-1:0] sig, sig_nxt;
  logic [MAX_W-1:0]  step_v, fold_v;

  always_comb begin
    step_v  = lfsr_step(MAX_W'(sig), MAX_W'(MISR_POLY), MISR_W);
    fold_v  = fold(MAX_W'(ns_i), STATE_W, MISR_W);
    sig_nxt = step_v[MISR_W-1:0] ^ fold_v[MISR_W-1:0];
  end

  // Signature tracks functional captures only; scan beats leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         sig <= '0;
    else if (sig_clr_i) sig <= '0;
    else if (cap_en)    sig <= sig_nxt;
  end

  assign sig_o = sig;
`endif

endmodule

// File: tb/tb_seq_state_wrapper.sv
// Directed bench for seq_state_wrapper (STATE_W=15, CHAINS=3); scan outputs and done
// pulses are checked by a monitor against queues filled by the stimulus.
module tb_seq_state_wrapper;

  localparam int SW = 15;
  localparam int CH = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [SW-1:0] ns_i = '0;
  logic [SW-1:0] ps_o;
  logic          run_en_i = 1'b0, step_i = 1'b0;
  logic          scan_start_i = 1'b0, scan_abort_i = 1'b0;
  logic          scan_ready_o, scan_done_o;
  logic          si_valid_i = 1'b0, so_ready_i = 1'b0;
  logic [CH-1:0] si_data_i = '0;
  logic [CH-1:0] so_data_o;
`ifdef STATE_MISR_EN
  logic [15:0]   sig_o;
  logic          sig_clr_i = 1'b0;
`endif

  int n_vec = 0;
  int n_bad = 0;

  logic [CH-1:0] exp_so[$];
  logic [SW-1:0] exp_done[$];

  seq_state_wrapper dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ns_i         (ns_i),
    .ps_o         (ps_o),
    .run_en_i     (run_en_i),
    .step_i       (step_i),
    .scan_start_i (scan_start_i),
    .scan_ready_o (scan_ready_o),
    .scan_abort_i (scan_abort_i),
    .si_valid_i   (si_valid_i),
    .si_data_i    (si_data_i),
    .so_ready_i   (so_ready_i),
    .so_data_o    (so_data_o),
`ifdef STATE_MISR_EN
    .sig_o        (sig_o),
    .sig_clr_i    (sig_clr_i),
`endif
    .scan_done_o  (scan_done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ps(input logic [SW-1:0] v);
    run_en_i = 1'b1;
    ns_i     = v;
    tick();
    run_en_i = 1'b0;
  endtask

  // Full scan: start, then CHAIN_LEN beats; stall inserts an idle cycle after each beat.
  task automatic run_scan(input logic [CH-1:0] si[5], input bit stall);
    scan_start_i = 1'b1;
    so_ready_i   = 1'b1;
    tick();
    scan_start_i = 1'b0;
    for (int b = 0; b < 5; b++) begin
      si_data_i  = si[b];
      si_valid_i = 1'b1;
      tick();
      if (stall) begin
        si_valid_i = 1'b0;
        so_ready_i = b[0];
        si_data_i  = 3'b111;
        tick();
        so_ready_i = 1'b1;
      end
    end
    si_valid_i = 1'b0;
    tick();
  endtask

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (scan_done_o) begin
        if (exp_done.size() == 0) check("done_unexpected", 32'(scan_done_o), 32'd0);
        else check("done_ps", 32'(ps_o), 32'(exp_done.pop_front()));
      end else if (!scan_ready_o && si_valid_i && so_ready_i && !scan_abort_i) begin
        if (exp_so.size() == 0) check("beat_unexpected", 32'(so_data_o), 32'hFFFF_FFFF);
        else check("beat_so", 32'(so_data_o), 32'(exp_so.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CH-1:0] zeros[5];
    logic [CH-1:0] swap_si[5];
    zeros   = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    swap_si = '{3'b101, 3'b010, 3'b111, 3'b000, 3'b110};

    repeat (2) @(posedge clk);
    #1;
    check("rst_ps", 32'(ps_o), 32'h0);
    check("rst_ready", 32'(scan_ready_o), 32'd1);
    check("rst_done", 32'(scan_done_o), 32'd0);
    check("rst_so", 32'(so_data_o), 32'h0);
`ifdef STATE_MISR_EN
    check("rst_sig", 32'(sig_o), 32'h0);
`endif
    rst_n = 1'b1;
    tick();

    // Free-run capture, single step, and hold with neither.
    load_ps(15'h1234);
    check("cap_ps", 32'(ps_o), 32'h1234);
    check("cap_ready", 32'(scan_ready_o), 32'd1);
    step_i = 1'b1; ns_i = 15'h0F0F;
    tick();
    step_i = 1'b0;
    check("step_ps", 32'(ps_o), 32'h0F0F);
    ns_i = 15'h7777;
    tick();
    check("hold_ps", 32'(ps_o), 32'h0F0F);

    // All-ones unload while loading zeros.
    load_ps(15'h7FFF);
    repeat (5) exp_so.push_back(3'b111);
    exp_done.push_back(15'h0000);
    run_scan(zeros, 1'b0);
    check("scan1_ready", 32'(scan_ready_o), 32'd1);

    // Same scan with valid/ready stalls between beats.
    load_ps(15'h7FFF);
    repeat (5) exp_so.push_back(3'b111);
    exp_done.push_back(15'h0000);
    run_scan(zeros, 1'b1);
    check("scan2_ps", 32'(ps_o), 32'h0);

    // Swap: 0x1234 exits as chain MSBs while a new pattern enters.
    load_ps(15'h1234);
    exp_so.push_back(3'b011); exp_so.push_back(3'b000); exp_so.push_back(3'b101);
    exp_so.push_back(3'b000); exp_so.push_back(3'b010);
    exp_done.push_back(15'h55B4);
    run_scan(swap_si, 1'b0);
    check("swap_ps", 32'(ps_o), 32'h55B4);

    // Abort after two beats; abort coincides with a valid handshake.
    load_ps(15'h7FFF);
    scan_start_i = 1'b1; so_ready_i = 1'b1; si_data_i = '0;
    tick();
    scan_start_i = 1'b0; si_valid_i = 1'b1;
    repeat (2) exp_so.push_back(3'b111);
    repeat (2) tick();
    scan_abort_i = 1'b1;
    tick();
    scan_abort_i = 1'b0; si_valid_i = 1'b0;
    check("abort_ready", 32'(scan_ready_o), 32'd1);
    check("abort_ps", 32'(ps_o), 32'h739C);
    tick();
    check("abort_nodone", 32'(exp_done.size()), 32'd0);

    // Start wins over run_en; run_en/step ignored in SHIFT.
    scan_start_i = 1'b1; run_en_i = 1'b1; ns_i = 15'h0AAA;
    tick();
    scan_start_i = 1'b0;
    check("coll_ready", 32'(scan_ready_o), 32'd0);
    check("coll_ps", 32'(ps_o), 32'h739C);
    step_i = 1'b1;
    tick();
    check("shift_step_ps", 32'(ps_o), 32'h739C);
    step_i = 1'b0; run_en_i = 1'b0; scan_abort_i = 1'b1;
    tick();
    scan_abort_i = 1'b0;
    check("coll_idle", 32'(scan_ready_o), 32'd1);

    // Async reset in the middle of a scan.
    load_ps(15'h1234);
    exp_so.push_back(3'b011);
    scan_start_i = 1'b1; so_ready_i = 1'b1; si_data_i = 3'b111;
    tick();
    scan_start_i = 1'b0; si_valid_i = 1'b1;
    tick();
    si_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_ps", 32'(ps_o), 32'h0);
    check("arst_ready", 32'(scan_ready_o), 32'd1);
    check("arst_done", 32'(scan_done_o), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_after", 32'(scan_ready_o), 32'd1);

`ifdef STATE_MISR_EN
    sig_clr_i = 1'b1;
    tick();
    sig_clr_i = 1'b0;
    check("sig_clr", 32'(sig_o), 32'h0);
    run_en_i = 1'b1; ns_i = 15'h0001;
    tick();
    check("sig_1", 32'(sig_o), 32'h0001);
    ns_i = 15'h0004;
    tick();
    run_en_i = 1'b0;
    check("sig_2", 32'(sig_o), 32'h0006);
`endif

    check("so_q_empty", 32'(exp_so.size()), 32'd0);
    check("done_q_empty", 32'(exp_done.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
